mem_line_responder: RTL and testbench

//  Memory-side responder for the cache controller's line-fetch interface.

---
 rtl/cache_mem_pkg.sv | 13 +
 rtl/mem_line_array.sv | 41 ++++
 rtl/mem_line_responder.sv | 122 ++++++++++++
 tb/tb_mem_line_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_pkg.sv
// Encodings and width defaults shared by cache_controller and the line memory.
package cache_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    localparam int CM_ADDR_W = 7;
    localparam int CM_LINE_W = 32;

endpackage

// File: rtl/mem_line_array.sv
// DEPTH x LINE_W line store: synchronous write, registered read.
// Only the read register is reset; the lines themselves are not.
module mem_line_array
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W = CM_ADDR_W,
    parameter int LINE_W = CM_LINE_W,
    parameter int DEPTH  = 2 ** CM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [LINE_W-1:0] o_rdata
);

    logic [LINE_W-1:0] r_mem [DEPTH];
    logic [LINE_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The read register doubles as the response data holder, so it keeps
    // its value whenever no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_line_responder.sv
// Single-outstanding line read/write responder with fixed access latency,
// serving the cache controller's line-fetch interface.
module mem_line_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W  = CM_ADDR_W,
    parameter int LINE_W  = CM_LINE_W,
    parameter int DEPTH   = 2 ** CM_ADDR_W,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [LINE_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_line_responder: LATENCY must be within 1..15");
    end
    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("mem_line_responder: DEPTH must equal 2**ADDR_W");
    end

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic              r_rsp_we;
    logic              w_accept;
    logic              w_enter_resp;
    logic [LINE_W-1:0] w_rdata;

    // r_cnt holds the WAIT cycles still to go, so an accept at edge N
    // reaches RESP at edge N+LATENCY, after the array write has landed.
    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept   = 1'b1;
                    w_cnt_next = CNT_LOAD;
                    w_next     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_enter_resp = 1'b1;
                    w_next       = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rsp_we <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_enter_resp) begin
                r_rsp_we <= r_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr <= req_addr;
            r_we   <= req_we;
        end
    end

    mem_line_array #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_accept & req_we),
        .i_waddr (req_addr),
        .i_wdata (req_wdata),
        .i_re    (w_enter_resp),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_we    = r_rsp_we;
    assign rsp_rdata = w_rdata;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: two instances (LATENCY 3 and 1), each with a
// transaction-level memory model checked every cycle, plus directed literals.
`timescale 1ns/1ps
module tb_mem_line_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 3 : 1;

        logic        rst_n     = 1'b0;
        logic        req_valid = 1'b0;
        logic        req_we    = 1'b0;
        logic        rsp_ready = 1'b0;
        logic [6:0]  req_addr  = '0;
        logic [31:0] req_wdata = '0;
        logic        req_ready;
        logic        rsp_valid;
        logic        rsp_we;
        logic        busy;
        logic [31:0] rsp_rdata;
        bit          done = 1'b0;

        mem_line_responder #(
            .ADDR_W  (7),
            .LINE_W  (32),
            .DEPTH   (128),
            .LATENCY (LAT)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_we    (req_we),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rsp_valid),
            .rsp_ready (rsp_ready),
            .rsp_we    (rsp_we),
            .rsp_rdata (rsp_rdata),
            .busy      (busy)
        );

        // Model: one pending transaction, "cycles left until response".
        logic [31:0] m_mem [128];
        bit          m_known [128];
        bit          m_pend   = 1'b0;
        int          m_left   = 0;
        logic [6:0]  m_addr   = '0;
        logic        m_we     = 1'b0;
        logic [31:0] m_rdata  = '0;
        logic        m_rwe    = 1'b0;
        bit          m_rknown = 1'b1;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_pend   = 1'b0;
                m_left   = 0;
                m_rdata  = '0;
                m_rwe    = 1'b0;
                m_rknown = 1'b1;
            end else if (!m_pend) begin
                if (req_valid) begin
                    m_pend = 1'b1;
                    m_left = LAT;
                    m_addr = req_addr;
                    m_we   = req_we;
                    if (req_we) begin
                        m_mem[req_addr]   = req_wdata;
                        m_known[req_addr] = 1'b1;
                    end
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_rdata  = m_mem[m_addr];
                    m_rknown = m_known[m_addr];
                    m_rwe    = m_we;
                end
            end else if (rsp_ready) begin
                m_pend = 1'b0;
            end
        end

        always @(negedge clk) begin
            chk($sformatf("g%0d req_ready", g), 32'(req_ready), 32'(!m_pend));
            chk($sformatf("g%0d busy", g), 32'(busy), 32'(m_pend));
            chk($sformatf("g%0d rsp_valid", g), 32'(rsp_valid), 32'(m_pend && (m_left == 0)));
            chk($sformatf("g%0d rsp_we", g), 32'(rsp_we), 32'(m_rwe));
            if (m_rknown) begin
                chk($sformatf("g%0d rsp_rdata", g), rsp_rdata, m_rdata);
            end
        end

        // One request/response; rsp_ready is withheld for 'hold' RESP cycles.
        task automatic xact(input logic we, input logic [6:0] a, input logic [31:0] d,
                            input int hold, output logic [31:0] rd, output logic rw,
                            output int lat);
            int t;
            t = 0;
            while (!req_ready && t < 40) begin
                @(posedge clk); #2;
                t++;
            end
            if (!req_ready) begin
                chk($sformatf("g%0d ready_timeout", g), 32'(req_ready), 32'd1);
            end
            req_valid = 1'b1;
            req_we    = we;
            req_addr  = a;
            req_wdata = d;
            @(posedge clk); #2;
            lat = 0;
            t   = 0;
            while (!rsp_valid && t < 40) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = 7'($urandom);
                req_wdata = $urandom;
                rsp_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #2;
                lat++;
                t++;
            end
            if (!rsp_valid) begin
                chk($sformatf("g%0d rsp_timeout", g), 32'(rsp_valid), 32'd1);
            end
            rd        = rsp_rdata;
            rw        = rsp_we;
            req_valid = 1'b0;
            rsp_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = 7'($urandom);
                req_wdata = $urandom;
                @(posedge clk); #2;
                chk($sformatf("g%0d stall_valid", g), 32'(rsp_valid), 32'd1);
                chk($sformatf("g%0d stall_ready", g), 32'(req_ready), 32'd0);
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
            @(posedge clk); #2;
            rsp_ready = 1'b0;
            chk($sformatf("g%0d post_hs_valid", g), 32'(rsp_valid), 32'd0);
            chk($sformatf("g%0d post_hs_ready", g), 32'(req_ready), 32'd1);
        endtask

        initial begin
            logic [31:0] rd;
            logic        rw;
            int          lat;
            rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #2;
            chk($sformatf("g%0d rst_ready", g), 32'(req_ready), 32'd1);
            chk($sformatf("g%0d rst_valid", g), 32'(rsp_valid), 32'd0);
            chk($sformatf("g%0d rst_busy", g), 32'(busy), 32'd0);
            chk($sformatf("g%0d rst_rdata", g), rsp_rdata, 32'd0);
            rst_n = 1'b1;
            @(posedge clk); #2;

            xact(1'b1, 7'd5, 32'h0706_0504, 0, rd, rw, lat);
            chk($sformatf("g%0d w5_lat", g), 32'(lat), (g == 0) ? 32'd3 : 32'd1);
            chk($sformatf("g%0d w5_we", g), 32'(rw), 32'd1);
            xact(1'b0, 7'd5, 32'h0, 0, rd, rw, lat);
            chk($sformatf("g%0d r5_lat", g), 32'(lat), (g == 0) ? 32'd3 : 32'd1);
            chk($sformatf("g%0d r5_data", g), rd, 32'h0706_0504);
            chk($sformatf("g%0d r5_we", g), 32'(rw), 32'd0);

            xact(1'b1, 7'd9, 32'hDEAD_BEEF, 0, rd, rw, lat);
            chk($sformatf("g%0d w9_data", g), rd, 32'hDEAD_BEEF);
            chk($sformatf("g%0d w9_we", g), 32'(rw), 32'd1);
            xact(1'b0, 7'd9, 32'h0, 0, rd, rw, lat);
            chk($sformatf("g%0d r9_data", g), rd, 32'hDEAD_BEEF);
            chk($sformatf("g%0d r9_we", g), 32'(rw), 32'd0);

            xact(1'b0, 7'd5, 32'h0, 5, rd, rw, lat);
            chk($sformatf("g%0d stall_data", g), rd, 32'h0706_0504);

            xact(1'b1, 7'd127, 32'hA5A5_007F, 0, rd, rw, lat);
            xact(1'b1, 7'd0, 32'h5A5A_0000, 0, rd, rw, lat);
            xact(1'b0, 7'd127, 32'h0, 0, rd, rw, lat);
            chk($sformatf("g%0d r127_data", g), rd, 32'hA5A5_007F);
            xact(1'b0, 7'd0, 32'h0, 0, rd, rw, lat);
            chk($sformatf("g%0d r0_data", g), rd, 32'h5A5A_0000);
            chk($sformatf("g%0d r0_lat", g), 32'(lat), (g == 0) ? 32'd3 : 32'd1);

            // Reset while the write to line 3 is in flight.
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 7'd3;
            req_wdata = 32'hC0FF_EE03;
            @(posedge clk); #2;
            req_valid = 1'b0;
            #1 rst_n = 1'b0;
            #1;
            chk($sformatf("g%0d midrst_valid", g), 32'(rsp_valid), 32'd0);
            chk($sformatf("g%0d midrst_busy", g), 32'(busy), 32'd0);
            chk($sformatf("g%0d midrst_ready", g), 32'(req_ready), 32'd1);
            chk($sformatf("g%0d midrst_rdata", g), rsp_rdata, 32'd0);
            @(posedge clk); #2;
            rst_n = 1'b1;
            @(posedge clk); #2;
            xact(1'b0, 7'd3, 32'h0, 0, rd, rw, lat);
            chk($sformatf("g%0d r3_data", g), rd, 32'hC0FF_EE03);

            for (int k = 0; k < 150; k++) begin
                xact(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), $urandom,
                     $urandom_range(0, 3), rd, rw, lat);
                chk($sformatf("g%0d rand_lat", g), 32'(lat), (g == 0) ? 32'd3 : 32'd1);
            end
            done = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_dut[0].done && g_dut[1].done) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("all_done", 32'(g_dut[0].done && g_dut[1].done), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
